// File: rtl/rtc_bus_sequencer_if.sv
// ---------------------------------------------------------------------------
// rtc_bus_sequencer_if
// Groups the request/response handshake and the RTC pin bundle used by
// rtc_bus_sequencer.
//   Request side : start, rw, addr, burst_len, wdata        (to sequencer)
//   Response side: wdata_ack, busy, done, rdata, rvalid     (from sequencer)
//   RTC pins     : cs_n, wr_n, rd_n, ad, dq_out, dq_oe      (from sequencer)
//                  dq_in                                    (to sequencer)
// master = the requester/RTC model side, slave = the sequencer itself.
// ---------------------------------------------------------------------------
interface rtc_bus_sequencer_if #(
    parameter int DW = 8,
    parameter int BW = 4
);
    logic          start;
    logic          rw;
    logic [DW-1:0] addr;
    logic [BW-1:0] burst_len;
    logic [DW-1:0] wdata;
    logic          wdata_ack;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          cs_n;
    logic          wr_n;
    logic          rd_n;
    logic          ad;
    logic [DW-1:0] dq_out;
    logic          dq_oe;
    logic [DW-1:0] dq_in;

    modport master (
        output start, rw, addr, burst_len, wdata, dq_in,
        input  wdata_ack, busy, done, rdata, rvalid,
               cs_n, wr_n, rd_n, ad, dq_out, dq_oe
    );

    modport slave (
        input  start, rw, addr, burst_len, wdata, dq_in,
        output wdata_ack, busy, done, rdata, rvalid,
               cs_n, wr_n, rd_n, ad, dq_out, dq_oe
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// ---------------------------------------------------------------------------
// rtc_bus_sequencer
// Runs multiplexed-address RTC bus bursts: for every transfer an address
// phase (ad low, address strobed with cs_n/wr_n), an idle gap, and a data
// phase (write strobe with wdata, or read strobe sampling dq_in). The
// address auto-increments between transfers of a burst.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - rtc_bus_sequencer_if.slave (request, response and RTC pins)
// Every output is a flop: the output decode of the current state is
// registered, so pin activity trails the internal state by one cycle.
// ---------------------------------------------------------------------------
module rtc_bus_sequencer #(
    parameter int DW    = 8,
    parameter int BW    = 4,
    parameter int T_INI = 2,
    parameter int T_AS  = 1,
    parameter int T_CS  = 5,
    parameter int T_AH  = 1,
    parameter int T_GAP = 12,
    parameter int T_DH  = 1
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bus_sequencer_if.slave bus
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_INI, T_AS), max2(T_CS, T_AH)), max2(T_GAP, T_DH));
    localparam int CW    = $clog2(T_MAX) + 1;

    typedef enum logic [3:0] {
        IDLE, INIT, A_SETUP, A_STROBE, A_HOLD, GAP, D_STROBE, D_HOLD, NEXT
    } state_t;

    typedef struct packed {
        logic          cs_n;
        logic          wr_n;
        logic          rd_n;
        logic          ad;
        logic          dq_oe;
        logic [DW-1:0] dq_out;
        logic          wdata_ack;
        logic          busy;
        logic          done;
        logic          rvalid;
        logic [DW-1:0] rdata;
    } out_t;

    localparam out_t OUT_RST = '{cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, ad: 1'b1,
                                 dq_oe: 1'b0, dq_out: DW'(0), wdata_ack: 1'b0,
                                 busy: 1'b0, done: 1'b0, rvalid: 1'b0, rdata: DW'(0)};

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] dur;
    logic          last_cycle;
    logic          rw_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [BW-1:0] rem_q;
    out_t          out_d, out_q;

    // Length of the current state; untimed states count as one cycle so the
    // phase counter stays parked at zero there.
    always_comb begin
        case (state)
            INIT:     dur = CW'(T_INI);
            A_SETUP:  dur = CW'(T_AS);
            A_STROBE: dur = CW'(T_CS);
            A_HOLD:   dur = CW'(T_AH);
            GAP:      dur = CW'(T_GAP);
            D_STROBE: dur = CW'(T_CS);
            D_HOLD:   dur = CW'(T_DH);
            default:  dur = CW'(1);
        endcase
    end

    assign last_cycle = (cnt == dur - CW'(1));

    // State register, phase counter and per-burst context.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rem_q   <= '0;
        end else begin
            state <= state_next;
            cnt   <= last_cycle ? '0 : cnt + CW'(1);
            if (state == IDLE && bus.start) begin
                rw_q   <= bus.rw;
                addr_q <= bus.addr;
                rem_q  <= (bus.burst_len == '0) ? BW'(1) : bus.burst_len;
            end
            if (state == NEXT) begin
                rem_q  <= rem_q - BW'(1);
                addr_q <= addr_q + DW'(1);
            end
            if (state == GAP && cnt == '0 && !rw_q)
                wdata_q <= bus.wdata;
        end
    end

    // Next-state logic. Timed states only advance on their last cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (bus.start)  state_next = INIT;
            INIT:     if (last_cycle) state_next = A_SETUP;
            A_SETUP:  if (last_cycle) state_next = A_STROBE;
            A_STROBE: if (last_cycle) state_next = A_HOLD;
            A_HOLD:   if (last_cycle) state_next = GAP;
            GAP:      if (last_cycle) state_next = D_STROBE;
            D_STROBE: if (last_cycle) state_next = D_HOLD;
            D_HOLD:   if (last_cycle) state_next = NEXT;
            NEXT:     state_next = (rem_q > BW'(1)) ? A_SETUP : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output decode of the current state, registered below.
    // NOTE: every field gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        out_d        = OUT_RST;
        out_d.rdata  = out_q.rdata;
        out_d.busy   = (state_next != IDLE);
        case (state)
            A_SETUP, A_HOLD: begin
                out_d.ad     = 1'b0;
                out_d.dq_oe  = 1'b1;
                out_d.dq_out = addr_q;
            end
            A_STROBE: begin
                out_d.ad     = 1'b0;
                out_d.cs_n   = 1'b0;
                out_d.wr_n   = 1'b0;
                out_d.dq_oe  = 1'b1;
                out_d.dq_out = addr_q;
            end
            GAP: begin
                if (!rw_q) begin
                    out_d.wdata_ack = (cnt == '0);
                    // Pre-drive write data one cycle ahead of the strobe.
                    if (last_cycle) begin
                        out_d.dq_oe  = 1'b1;
                        out_d.dq_out = wdata_q;
                    end
                end
            end
            D_STROBE: begin
                out_d.cs_n = 1'b0;
                if (rw_q) begin
                    out_d.rd_n = 1'b0;
                end else begin
                    out_d.wr_n   = 1'b0;
                    out_d.dq_oe  = 1'b1;
                    out_d.dq_out = wdata_q;
                end
            end
            D_HOLD: begin
                if (!rw_q) begin
                    out_d.dq_oe  = 1'b1;
                    out_d.dq_out = wdata_q;
                end else if (cnt == '0) begin
                    // This edge is the one where rd_n rises on the pins.
                    out_d.rdata  = bus.dq_in;
                    out_d.rvalid = 1'b1;
                end
            end
            NEXT:    out_d.done = (rem_q <= BW'(1));
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_q <= OUT_RST;
        else        out_q <= out_d;
    end

    assign bus.cs_n      = out_q.cs_n;
    assign bus.wr_n      = out_q.wr_n;
    assign bus.rd_n      = out_q.rd_n;
    assign bus.ad        = out_q.ad;
    assign bus.dq_oe     = out_q.dq_oe;
    assign bus.dq_out    = out_q.dq_out;
    assign bus.wdata_ack = out_q.wdata_ack;
    assign bus.busy      = out_q.busy;
    assign bus.done      = out_q.done;
    assign bus.rvalid    = out_q.rvalid;
    assign bus.rdata     = out_q.rdata;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_sequencer
// Two sequencer instances: u_dut0 with default timing and u_dut1 with
// T_CS=2, T_GAP=2. A timeline reference model predicts every output for
// every cycle of a transaction from the phase lengths, and the pins are
// compared once per cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_rtc_bus_sequencer;

    typedef struct packed {
        logic       cs_n;
        logic       wr_n;
        logic       rd_n;
        logic       ad;
        logic       dq_oe;
        logic [7:0] dq_out;
        logic       wdata_ack;
        logic       busy;
        logic       done;
        logic       rvalid;
        logic [7:0] rdata;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       sel;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [3:0] burst_len;
    logic [7:0] wdata;
    logic [7:0] dq_in;

    int n_pass  = 0;
    int n_total = 0;

    // Timing of the instance under test.
    int t_ini, t_as, t_cs, t_ah, t_gap, t_dh;

    // Current transaction and values present at each rising edge.
    bit         cur_rw;
    int         cur_addr;
    int         cur_n;
    logic [7:0] drv_wd [1024];
    logic [7:0] drv_dq [1024];
    logic [7:0] rdata_model;

    rtc_bus_sequencer_if #(.DW(8), .BW(4)) bus0 ();
    rtc_bus_sequencer_if #(.DW(8), .BW(4)) bus1 ();

    assign bus0.start     = start & ~sel;
    assign bus0.rw        = rw;
    assign bus0.addr      = addr;
    assign bus0.burst_len = burst_len;
    assign bus0.wdata     = wdata;
    assign bus0.dq_in     = dq_in;
    assign bus1.start     = start & sel;
    assign bus1.rw        = rw;
    assign bus1.addr      = addr;
    assign bus1.burst_len = burst_len;
    assign bus1.wdata     = wdata;
    assign bus1.dq_in     = dq_in;

    rtc_bus_sequencer u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    rtc_bus_sequencer #(.T_CS(2), .T_GAP(2)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_params(input bit s);
        sel   = s;
        t_ini = 2;
        t_as  = 1;
        t_cs  = s ? 2 : 5;
        t_ah  = 1;
        t_gap = s ? 2 : 12;
        t_dh  = 1;
    endtask

    function automatic int p_len();
        return t_as + 2 * t_cs + t_ah + t_gap + t_dh + 1;
    endfunction

    function automatic vec_t quiet_vec(input logic [7:0] rd);
        vec_t v;
        v = '0;
        v.cs_n  = 1'b1;
        v.wr_n  = 1'b1;
        v.rd_n  = 1'b1;
        v.ad    = 1'b1;
        v.rdata = rd;
        return v;
    endfunction

    // Expected pins for cycle c after the start edge (c=0 is the cycle
    // right after the accepting edge), built from the phase lengths.
    function automatic vec_t model(input int c);
        vec_t e;
        int   p, a_end, g_end, s_end, last, k, j, s;
        logic [7:0] ad_k, wcap;
        p     = p_len();
        a_end = t_as + t_cs + t_ah;
        g_end = a_end + t_gap;
        s_end = g_end + t_cs;
        last  = t_ini + cur_n * p;
        e      = quiet_vec(rdata_model);
        e.busy = (c < last);
        e.done = (c == last);
        if (c > t_ini && c <= last) begin
            k    = (c - t_ini - 1) / p;
            j    = (c - t_ini - 1) % p + 1;
            s    = t_ini + k * p;
            ad_k = 8'((cur_addr + k) % 256);
            wcap = drv_wd[s + a_end + 1];
            if (j <= a_end) begin
                e.ad     = 1'b0;
                e.dq_oe  = 1'b1;
                e.dq_out = ad_k;
                if (j > t_as && j <= t_as + t_cs) begin
                    e.cs_n = 1'b0;
                    e.wr_n = 1'b0;
                end
            end else if (j <= g_end) begin
                if (!cur_rw) begin
                    e.wdata_ack = (j == a_end + 1);
                    if (j == g_end) begin
                        e.dq_oe  = 1'b1;
                        e.dq_out = wcap;
                    end
                end
            end else if (j <= s_end) begin
                e.cs_n = 1'b0;
                if (cur_rw) begin
                    e.rd_n = 1'b0;
                end else begin
                    e.wr_n   = 1'b0;
                    e.dq_oe  = 1'b1;
                    e.dq_out = wcap;
                end
            end else if (j <= s_end + t_dh) begin
                if (!cur_rw) begin
                    e.dq_oe  = 1'b1;
                    e.dq_out = wcap;
                end else if (j == s_end + 1) begin
                    e.rvalid = 1'b1;
                    e.rdata  = drv_dq[c];
                end
            end
        end
        return e;
    endfunction

    function automatic vec_t observe();
        vec_t o;
        if (!sel) o = '{bus0.cs_n, bus0.wr_n, bus0.rd_n, bus0.ad, bus0.dq_oe, bus0.dq_out,
                        bus0.wdata_ack, bus0.busy, bus0.done, bus0.rvalid, bus0.rdata};
        else      o = '{bus1.cs_n, bus1.wr_n, bus1.rd_n, bus1.ad, bus1.dq_oe, bus1.dq_out,
                        bus1.wdata_ack, bus1.busy, bus1.done, bus1.rvalid, bus1.rdata};
        return o;
    endfunction

    // dq_out only carries meaning while the model expects it driven,
    // except under reset where it must read zero.
    task automatic check_vec(input string tag, input int c, input vec_t exp, input bit mask_dq);
        vec_t obs;
        obs = observe();
        if (mask_dq && !exp.dq_oe) obs.dq_out = '0;
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
    endtask

    task automatic drive_random(input int idx, input bit allow_start, input bit force_start);
        start     = allow_start && (force_start || $urandom_range(7) == 0);
        rw        = 1'($urandom_range(1));
        addr      = 8'($urandom);
        burst_len = 4'($urandom);
        wdata     = 8'($urandom);
        dq_in     = 8'($urandom);
        drv_wd[idx] = wdata;
        drv_dq[idx] = dq_in;
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_vec(tag, i, quiet_vec(rdata_model), 1'b1);
            drive_random(0, 1'b0, 1'b0);
        end
    endtask

    // Issues a start at the current falling edge and checks every cycle up
    // to and including the done cycle, or up to stop_at when stop_at >= 0.
    // Request fields and stray start pulses are scrambled while busy.
    task automatic run_txn(input string tag, input bit rw_i, input int addr_i,
                           input int len_i, input int stop_at);
        int   last;
        vec_t e;
        start     = 1'b1;
        rw        = rw_i;
        addr      = 8'(addr_i);
        burst_len = 4'(len_i);
        wdata     = 8'($urandom);
        dq_in     = 8'($urandom);
        drv_wd[0] = wdata;
        drv_dq[0] = dq_in;
        cur_rw    = rw_i;
        cur_addr  = addr_i;
        cur_n     = (len_i == 0) ? 1 : len_i;
        last      = t_ini + cur_n * p_len();
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            @(negedge clk);
            e = model(c);
            check_vec(tag, c, e, 1'b1);
            rdata_model = e.rdata;
            if (c == stop_at) return;
            drive_random(c + 1, c < last, c == 10);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        rw        = 1'b0;
        addr      = '0;
        burst_len = '0;
        wdata     = '0;
        dq_in     = '0;
        rdata_model = '0;
        set_params(1'b0);

        repeat (2) begin
            @(negedge clk);
            check_vec("reset_state", 0, quiet_vec(8'h00), 1'b0);
        end
        reset = 1'b1;
        idle_cycles("idle_after_reset", 3);

        run_txn("single_write", 1'b0, 'h0A, 1, -1);
        idle_cycles("idle_w", 2);
        run_txn("single_read", 1'b1, 'h0C, 1, -1);
        idle_cycles("idle_r", 1);
        run_txn("write_burst_wrap", 1'b0, 'hFE, 3, -1);
        run_txn("read_burst_wrap", 1'b1, 'hFF, 2, -1);

        for (int i = 0; i < 6; i++) begin
            run_txn("random_txn", 1'($urandom_range(1)), int'($urandom_range(255)),
                    int'($urandom_range(4)), -1);
            if ($urandom_range(1) == 1) idle_cycles("random_gap", int'($urandom_range(3)) + 1);
        end

        // Abort a read in the middle of its data strobe.
        run_txn("read_before_abort", 1'b1, int'($urandom_range(255)), 2,
                t_ini + t_as + t_cs + t_ah + t_gap + 2);
        #2 reset = 1'b0;
        start = 1'b0;
        #1 check_vec("reset_async", 0, quiet_vec(8'h00), 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_vec("reset_hold", i, quiet_vec(8'h00), 1'b0);
        end
        reset = 1'b1;
        rdata_model = '0;
        idle_cycles("idle_after_abort", 5);
        run_txn("read_after_abort", 1'b1, int'($urandom_range(255)), 1, -1);
        idle_cycles("idle_end0", 2);

        // Short-timing instance: burst_len=0 runs exactly one transfer.
        set_params(1'b1);
        rdata_model = '0;
        idle_cycles("idle_dut1", 2);
        run_txn("len0_read_short", 1'b1, int'($urandom_range(255)), 0, -1);
        idle_cycles("idle_len0", 3);
        run_txn("len0_write_short", 1'b0, int'($urandom_range(255)), 0, -1);
        run_txn("burst_short", 1'b0, int'($urandom_range(255)), 3, -1);
        idle_cycles("idle_end1", 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 Parameter DW, 8, data/address bus width (min 4).
REQ-002 Parameter BW, 4, burst-length field width; max burst is 2^BW-1 transfers.
REQ-003 Parameter T_INI, 2, idle cycles between start acceptance and first bus activity (min 1).
REQ-004 Parameter T_AS, 1, cycles AD low before CS falls in the address phase (min 1).
REQ-005 Parameter T_CS, 5, strobe-low cycles per phase (min 2).
REQ-006 Parameter T_AH, 1, cycles AD held low after address strobe rises (min 1).
REQ-007 Parameter T_GAP, 12, cycles with all strobes high between address and data phases (min 2).
REQ-008 Parameter T_DH, 1, write-data hold cycles after data strobe rises (min 1).
REQ-009 clk  in  1  rising-edge clock.
REQ-010 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-011 start  in  1  request pulse, sampled only in IDLE.
REQ-012 rw  in  1  1 = read, 0 = write; sampled with start.
REQ-013 addr  in  DW  first register address; sampled with start.
REQ-014 burst_len  in  BW  transfer count; sampled with start.
REQ-015 wdata  in  DW  write data for the current transfer.
REQ-016 wdata_ack  out  1  one-cycle pulse when wdata has been captured.
REQ-017 busy  out  1  high from the cycle after start acceptance until done.
REQ-018 done  out  1  one-cycle pulse at end of the whole burst.
REQ-019 rdata  out  DW  captured read data; rvalid  out  1  one-cycle qualifier.
REQ-020 cs_n, wr_n, rd_n, ad  out  1 each  RTC strobes; ad low marks the address phase.
REQ-021 dq_out  out  DW, dq_oe  out  1, dq_in  in  DW  tristate data bus split.

Function
REQ-022 All outputs are registered; no output has a combinational path from any input.
REQ-023 FSM states: IDLE, INIT, A_SETUP, A_STROBE, A_HOLD, GAP, D_STROBE, D_HOLD, NEXT; each timed state lasts exactly its parameter count in cycles.
REQ-024 IDLE: start=1 moves to INIT; rw, addr, and burst_len are latched; burst_len=0 is treated as 1.
REQ-025 A_SETUP: ad=0, dq_oe=1, dq_out=current address, and all other strobes high.
REQ-026 A_STROBE: ad=0, cs_n=0, wr_n=0, dq_oe=1, and dq_out=address.
REQ-027 A_HOLD: ad=0, cs_n=1, wr_n=1, dq_oe=1, and dq_out=address.
REQ-028 GAP: ad=1 and all strobes high.
REQ-029 GAP, write: wdata is captured in the first GAP cycle, and wdata_ack pulses in that cycle.
REQ-030 GAP, write: dq_oe=1 with dq_out=captured wdata in the last GAP cycle.
REQ-031 D_STROBE: cs_n=0, with wr_n=0 for a write or rd_n=0 for a read.
REQ-032 D_STROBE: dq_oe=1 for a write and 0 for a read.
REQ-033 Read: dq_in is sampled into rdata on the last D_STROBE cycle; rvalid pulses in the following cycle.
REQ-034 D_HOLD: all strobes high; for a write, dq_oe=1 with data held; for a read, dq_oe=0.
REQ-035 NEXT lasts one cycle; it decrements the remaining count and increments the address modulo 2^DW (0xFF wraps to 0x00 for DW=8).
REQ-036 NEXT with remaining count > 0 goes to A_SETUP (no INIT); otherwise done=1 and the FSM goes to IDLE.
REQ-037 Single-transfer latency: done asserts T_INI+T_AS+2*T_CS+T_AH+T_GAP+T_DH+1 cycles after the start edge (28 with defaults).
REQ-038 Each additional burst transfer adds T_AS+2*T_CS+T_AH+T_GAP+T_DH+1 cycles.
REQ-039 start while busy=1 is ignored, with no queuing.
REQ-040 start is accepted in IDLE in the same cycle done drops.
REQ-041 rw, addr, and burst_len changing during a burst have no effect.
REQ-042 Phase counters are sized by $clog2 of the largest timing parameter plus 1, and never wrap within a state.

Reset
REQ-043 reset=0 forces IDLE immediately, independent of clk.
REQ-044 During reset: cs_n=wr_n=rd_n=ad=1, dq_oe=0, dq_out=0, rdata=0, and busy=done=rvalid=wdata_ack=0.
REQ-045 Reset mid-burst aborts the burst; no done and no rvalid are produced.
REQ-046 After reset release, the FSM waits in IDLE for a new start.

Verification
REQ-047 Single write, defaults (addr 0x0A, wdata 0x55): address phase cs_n/wr_n low 5 cycles with dq=0x0A; 12-cycle gap; data phase cs_n/wr_n low 5 cycles with dq=0x55; done at cycle 28.
REQ-048 Single read (addr 0x0C, dq_in=0xA3 during D_STROBE): rd_n low 5 cycles, wr_n high in the data phase, dq_oe=0 in the data phase, rdata=0xA3 with rvalid one cycle after the strobe.
REQ-049 Write burst_len=3 from addr 0xFE: addresses 0xFE, 0xFF, 0x00 are driven, three wdata_ack pulses occur, and a single done pulse occurs 28+2*26 cycles after start.
REQ-050 start pulsed at cycle 10 of an active transfer: it is ignored; busy stays high and exactly one done pulse occurs.
REQ-051 reset asserted during D_STROBE of a read: all strobes high and dq_oe=0 within the same cycle; no rvalid and no done; a new start after release runs normally.
REQ-052 burst_len=0 with T_CS=2 and T_GAP=2: exactly one transfer; strobe-low widths of 2 cycles match the parameters.
